detector_meas_ctrl: RTL and testbench

//  Sequences one measurement on the edge Detector outputs. start arms the block. It waits
//  for a rising event, then times the high phase (rise->fall) and the period (rise->rise).
//  The result goes out on a valid/ready handshake. Sits between the RNM Detector (via its
//  1-bit logic-level edge outputs) and the digital control/readout logic.

---
 rtl/detector_ctrl_pkg.sv | 22 ++
 rtl/edge_sync_pulse.sv | 41 ++++
 rtl/detector_meas_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_detector_meas_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detector_ctrl_pkg.sv
// Shared types for the detector measurement controller.
//   meas_state_t : sequencer states
//   meas_err_t   : result status code reported alongside the counts
`timescale 1ns / 1ps

package detector_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        HIGH   = 3'd2,
        LOW    = 3'd3,
        REPORT = 3'd4
    } meas_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_SEQ     = 2'd2
    } meas_err_t;

endpackage

// File: rtl/edge_sync_pulse.sv
// Synchronizes an asynchronous level/pulse into the clk domain and emits a registered
// one-cycle pulse on each rising edge of the synchronized signal.
// Input-to-pulse latency is SYNC_STAGES+1 cycles, identical for every instance.
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   async_in : asynchronous input
//   pulse    : one-cycle rising-edge pulse
`timescale 1ns / 1ps

module edge_sync_pulse #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("edge_sync_pulse: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/detector_meas_ctrl.sv
// Sequences one high-time / period measurement on the Detector edge outputs.
// start arms the block; the first rise starts the count, a fall latches the high time and
// a second rise latches the period. The result is offered on a valid/ready handshake.
//   clk, rst_n             : clock, synchronous active-low reset
//   start, abort           : arm / cancel a measurement
//   rise_in, fall_in       : asynchronous Detector edge pulses
//   busy                   : measurement in progress or result pending
//   meas_valid, meas_ready : result handshake
//   high_cnt, period_cnt   : rise->fall and rise->rise cycle counts
//   err                    : 00 ok, 01 timeout, 10 sequence error
`timescale 1ns / 1ps

module detector_meas_ctrl
    import detector_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             rise_in,
    input  logic             fall_in,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [1:0]       err
);

    localparam longint unsigned MaxTimeout = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] One        = CNT_W'(1);

    if (TIMEOUT < 2 || 64'(TIMEOUT) > MaxTimeout) begin : g_bad_timeout
        $error("detector_meas_ctrl: TIMEOUT must satisfy 2 <= TIMEOUT <= 2**CNT_W-1");
    end

    logic rise_ev;
    logic fall_ev;

    edge_sync_pulse #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rise_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rise_in),
        .pulse    (rise_ev)
    );

    edge_sync_pulse #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_fall_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (fall_in),
        .pulse    (fall_ev)
    );

    meas_state_t      state_q, state_d;
    meas_err_t        err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] wait_inc;
    logic             timeout_hit;
    logic             do_arm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            err_q    <= ERR_NONE;
            cnt_q    <= '0;
            wait_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            high_q   <= high_d;
            period_q <= period_d;
        end
    end

    // The wait counter reaches TIMEOUT on the edge that leaves the waiting state, so an
    // event arriving on that same edge is still accepted (events beat timeout).
    assign wait_inc    = wait_q + One;
    assign timeout_hit = (wait_inc == TimeoutCnt);

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        high_d   = high_q;
        period_d = period_q;
        do_arm   = 1'b0;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    do_arm = start;
                end
                ARMED: begin
                    wait_d = wait_inc;
                    if (rise_ev) begin
                        state_d = HIGH;
                        cnt_d   = One;
                        wait_d  = '0;
                    end else if (timeout_hit) begin
                        state_d = REPORT;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                HIGH: begin
                    cnt_d  = cnt_q + One;
                    wait_d = wait_inc;
                    if (fall_ev && rise_ev) begin
                        // Fall is taken first; the coincident rise is then a second rise
                        // without a full low phase.
                        high_d   = cnt_q;
                        period_d = cnt_q;
                        err_d    = ERR_SEQ;
                        state_d  = REPORT;
                    end else if (fall_ev) begin
                        high_d  = cnt_q;
                        wait_d  = '0;
                        state_d = LOW;
                    end else if (rise_ev) begin
                        period_d = cnt_q;
                        err_d    = ERR_SEQ;
                        state_d  = REPORT;
                    end else if (timeout_hit) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = REPORT;
                    end
                end
                LOW: begin
                    cnt_d  = cnt_q + One;
                    wait_d = wait_inc;
                    if (rise_ev) begin
                        period_d = cnt_q;
                        state_d  = REPORT;
                    end else if (fall_ev) begin
                        err_d   = ERR_SEQ;
                        state_d = REPORT;
                    end else if (timeout_hit) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = REPORT;
                    end
                end
                REPORT: begin
                    if (meas_ready) begin
                        state_d = IDLE;
                        do_arm  = start;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (do_arm) begin
            state_d  = ARMED;
            err_d    = ERR_NONE;
            cnt_d    = '0;
            wait_d   = '0;
            high_d   = '0;
            period_d = '0;
        end
    end

    assign busy       = (state_q != IDLE);
    assign meas_valid = (state_q == REPORT);
    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign err        = err_q;

endmodule

// File: tb/tb_detector_meas_ctrl.sv
`timescale 1ns / 1ps

module tb_detector_meas_ctrl;

    localparam int CntW    = 16;
    localparam int Timeout = 64;
    localparam int Lat     = 3;   // input-to-event latency with two sync stages

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            rise_in = 1'b0;
    logic            fall_in = 1'b0;
    logic            meas_ready = 1'b0;
    logic            busy;
    logic            meas_valid;
    logic [CntW-1:0] high_cnt;
    logic [CntW-1:0] period_cnt;
    logic [1:0]      err;

    detector_meas_ctrl #(
        .CNT_W       (CntW),
        .TIMEOUT     (Timeout),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .rise_in    (rise_in),
        .fall_in    (fall_in),
        .busy       (busy),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Event schedule: d = drive offset (cycles after arming), k bit0 = rise, bit1 = fall.
    typedef struct {
        string      name;
        int         ne;
        int         d [4];
        logic [1:0] k [4];
        int         high;
        int         period;
        int         err;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input int ne,
                           input int d0, input int k0, input int d1, input int k1,
                           input int d2, input int k2, input int d3, input int k3,
                           input int h, input int p, input int e);
        vec_t v;
        v.name = name; v.ne = ne;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.k[0] = 2'(k0); v.k[1] = 2'(k1); v.k[2] = 2'(k2); v.k[3] = 2'(k3);
        v.high = h; v.period = p; v.err = e;
        vecs.push_back(v);
    endtask

    // Reference: walk the event times; measurements are plain time differences.
    function automatic void model(input vec_t v, output int h, output int p, output int e);
        int  ref_t;
        int  r1;
        int  phase;
        int  t;
        bit  done;
        ref_t = 0; r1 = 0; phase = 0; done = 0;
        h = 0; p = 0; e = 1;
        for (int i = 0; i < v.ne; i++) begin
            if (!done) begin
                t = v.d[i] + Lat;
                if (t - ref_t > Timeout) begin
                    e = 1; done = 1;
                end else if (phase == 0) begin
                    if (v.k[i][0]) begin r1 = t; ref_t = t; phase = 1; end
                end else if (phase == 1) begin
                    if (v.k[i] == 2'b11) begin
                        h = t - r1; p = t - r1; e = 2; done = 1;
                    end else if (v.k[i][1]) begin
                        h = t - r1; ref_t = t; phase = 2;
                    end else begin
                        p = t - r1; e = 2; done = 1;
                    end
                end else begin
                    if (v.k[i][0]) begin p = t - r1; e = 0; end
                    else e = 2;
                    done = 1;
                end
            end
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the arming edge.
    task automatic arm();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Must be called at the negedge just after the arming edge.
    task automatic drive(input vec_t v);
        bit lr [0:511];
        bit lf [0:511];
        int last;
        last = 0;
        for (int i = 0; i < v.ne; i++) begin
            if (v.k[i][0]) begin lr[v.d[i]] = 1'b1; lr[v.d[i]+1] = 1'b1; end
            if (v.k[i][1]) begin lf[v.d[i]] = 1'b1; lf[v.d[i]+1] = 1'b1; end
            if (v.d[i] + 2 > last) last = v.d[i] + 2;
        end
        for (int o = 1; o <= last; o++) begin
            rise_in = lr[o];
            fall_in = lf[o];
            @(negedge clk);
        end
        rise_in = 1'b0;
        fall_in = 1'b0;
    endtask

    task automatic collect(input string name, input int eh, input int ep, input int ee,
                           input int hold, input bit rearm);
        int n;
        n = 0;
        while (!meas_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"}, int'(meas_valid), 1);
        if (!meas_valid) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            repeat (8) @(negedge clk);
            return;
        end
        check({name, " err"}, int'(err), ee);
        check({name, " high_cnt"}, int'(high_cnt), eh);
        check({name, " period_cnt"}, int'(period_cnt), ep);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold valid"}, int'(meas_valid), 1);
            check({name, " hold busy"}, int'(busy), 1);
            check({name, " hold high_cnt"}, int'(high_cnt), eh);
            check({name, " hold period_cnt"}, int'(period_cnt), ep);
            check({name, " hold err"}, int'(err), ee);
        end
        meas_ready = 1'b1;
        start      = rearm;
        @(negedge clk);
        meas_ready = 1'b0;
        start      = 1'b0;
        check({name, " valid after ack"}, int'(meas_valid), 0);
        check({name, " busy after ack"}, int'(busy), int'(rearm));
        if (!rearm) repeat (8) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, " busy"}, int'(busy), 0);
        check({name, " valid"}, int'(meas_valid), 0);
        check({name, " high_cnt"}, int'(high_cnt), 0);
        check({name, " period_cnt"}, int'(period_cnt), 0);
        check({name, " err"}, int'(err), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   h, p, e, n, sel, g, cur;
        bit   flag;

        //       name              ne  d0 k0  d1 k1  d2 k2  d3 k3  high period err
        add_vec("basic",            3,  5, 1, 15, 2, 25, 1,  0, 0,  10, 20, 0);
        add_vec("no edges",         0,  0, 0,  0, 0,  0, 0,  0, 0,   0,  0, 1);
        add_vec("double rise",      2,  5, 1, 20, 1,  0, 0,  0, 0,   0, 15, 2);
        add_vec("double fall",      3,  5, 1, 12, 2, 20, 2,  0, 0,   7,  0, 2);
        add_vec("armed fall ign",   4,  3, 2,  8, 1, 14, 2, 30, 1,   6, 22, 0);
        add_vec("both in high",     2,  5, 1, 17, 3,  0, 0,  0, 0,  12, 12, 2);
        add_vec("both in armed",    3,  5, 3, 13, 2, 20, 1,  0, 0,   8, 15, 0);
        add_vec("both in low",      3,  5, 1, 10, 2, 25, 3,  0, 0,   5, 20, 0);
        add_vec("timeout high",     1,  5, 1,  0, 0,  0, 0,  0, 0,   0,  0, 1);
        add_vec("timeout low",      2,  5, 1,  9, 2,  0, 0,  0, 0,   4,  0, 1);
        add_vec("armed edge in",    3, 61, 1, 71, 2, 81, 1,  0, 0,  10, 20, 0);
        add_vec("armed edge late",  1, 62, 1,  0, 0,  0, 0,  0, 0,   0,  0, 1);
        add_vec("high edge in",     3,  5, 1, 69, 2, 79, 1,  0, 0,  64, 74, 0);
        add_vec("high edge late",   2,  5, 1, 70, 2,  0, 0,  0, 0,   0,  0, 1);

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            arm();
            drive(vecs[i]);
            collect(vecs[i].name, vecs[i].high, vecs[i].period, vecs[i].err, 2, 1'b0);
        end

        // Timeout latency from arming, busy held throughout
        arm();
        n = 0; flag = 0;
        while (!meas_valid && n < 100) begin
            if (!busy) flag = 1;
            @(negedge clk);
            n++;
        end
        check("timeout latency", n, Timeout);
        check("timeout busy low", int'(flag), 0);
        collect("timeout", 0, 0, 1, 3, 1'b0);

        // Backpressure for 30 cycles, then re-arm in the handshake cycle
        arm();
        drive(vecs[0]);
        collect("backpressure", 10, 20, 0, 30, 1'b1);
        drive(vecs[0]);
        collect("rearmed", 10, 20, 0, 1, 1'b0);

        // Abort while HIGH
        arm();
        rise_in = 1'b1;
        repeat (2) @(negedge clk);
        rise_in = 1'b0;
        repeat (4) @(negedge clk);
        check("abort pre busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort valid", int'(meas_valid), 0);
        flag = 0;
        repeat (80) begin
            @(negedge clk);
            if (meas_valid || busy) flag = 1;
        end
        check("abort stays idle", int'(flag), 0);

        // Reset mid-LOW, then a clean measurement
        v = vecs[0];
        v.ne = 2;
        arm();
        drive(v);
        repeat (3) @(negedge clk);
        check("pre-reset busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zero("mid-low reset");
        repeat (3) @(negedge clk);
        arm();
        drive(vecs[0]);
        collect("after reset", 10, 20, 0, 1, 1'b0);

        // Randomized schedules against the reference model
        for (int t = 0; t < 40; t++) begin
            v.name = "random";
            v.ne = int'($urandom_range(0, 4));
            cur = 0;
            for (int i = 0; i < 4; i++) begin v.d[i] = 0; v.k[i] = 2'b00; end
            for (int i = 0; i < v.ne; i++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 7) g = int'($urandom_range(4, 30));
                else if (sel < 9) g = int'($urandom_range(58, 66));
                else g = int'($urandom_range(70, 90));
                cur = cur + g;
                v.d[i] = cur;
                sel = int'($urandom_range(0, 9));
                v.k[i] = (sel < 5) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            end
            model(v, h, p, e);
            arm();
            drive(v);
            collect("random", h, p, e, int'($urandom_range(0, 4)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
